angle_sequencer: RTL and testbench
==================================

ANGLE_SEQUENCER -- requirements
Module: angle_sequencer

Interface
REQ-001 SHALL have parameter p_WIDTH, default 32, angle word width in bits.
REQ-002 SHALL have parameter p_ANGLE_ADDR_WIDTH, default 5, offset width; table depth 2^p_ANGLE_ADDR_WIDTH per system.
REQ-003 SHALL have ports:
 clk  in  1  single clock, all logic rising-edge.
 reset  in  1  synchronous, active-high.
 start_valid  in  1  run request.
 start_ready  out  1  high only in IDLE.
 start_system  in  1  1 = circular (atan), 0 = hyperbolic (atanh).
 start_count  in  p_ANGLE_ADDR_WIDTH  number of distinct offsets to issue.
 abort  in  1  cancel current run.
 step_valid  out  1  step word present.
 step_ready  in  1  consumer accepts step.
 step_offset  out  p_ANGLE_ADDR_WIDTH  shift amount for this iteration.
 step_angle  out  p_WIDTH  table angle for step_offset.
 step_repeat  out  1  step is a hyperbolic repeat.
 step_last  out  1  final step of run.
 done  out  1  one-cycle pulse, run complete.
 busy  out  1  high in RUN.

Function
REQ-004 Circular table entry i SHALL be atan(2^-i) scaled so full turn = 2^p_WIDTH, truncated toward zero (p_WIDTH=32: entry0 = 0x20000000, entry1 = 0x12E4051D).
REQ-005 Hyperbolic table entry 0 SHALL be 0; entry i>=1 = atanh(2^-i) x 2^(p_WIDTH-1), truncated (p_WIDTH=32: entry1 = 0x464FA9EA, entry10 = 0x00200000).
REQ-006 Table contents SHALL be constants fixed at elaboration; entries that truncate to 0 SHALL be 0.
REQ-007 FSM states SHALL be IDLE and RUN; done is a registered pulse, not a state.
REQ-008 IDLE->RUN SHALL occur on start_valid && start_ready with start_count != 0; mode and count latched that edge.
REQ-009 Accepted start with start_count = 0 SHALL stay IDLE and pulse done next cycle, no steps.
REQ-010 Circular run SHALL issue offsets 0,1,...,start_count-1, step_repeat = 0.
REQ-011 Hyperbolic run SHALL issue offsets 1,2,...,start_count; offsets 4, 13, 40, ... (k' = 3k+1) issued twice consecutively, second issue with step_repeat = 1.
REQ-012 Hyperbolic offset never SHALL exceed 2^p_ANGLE_ADDR_WIDTH-1; start_count at max issues through max offset.
REQ-013 First step SHALL be valid the cycle after start acceptance (latency 1); step_angle, step_offset, step_repeat, step_last SHALL be registered, consistent with each other.
REQ-014 Step output SHALL hold stable while step_valid && !step_ready; advance exactly one step per cycle with step_ready high (full throughput).
REQ-015 step_last SHALL be 1 only on final step (the repeat copy if the final offset is a repeat offset).
REQ-016 After last step handshake: next cycle step_valid = 0, busy = 0, done = 1, start_ready = 1.
REQ-017 abort in RUN SHALL force IDLE next cycle, step_valid = 0, no done pulse; abort in IDLE SHALL have no effect; abort SHALL win over a same-cycle step handshake.
REQ-018 start_valid during RUN SHALL be ignored (start_ready = 0).
REQ-019 Offset/step counters SHALL not wrap; counter width sufficient for start_count plus repeats.

Reset
REQ-020 reset SHALL override all inputs including abort and start.
REQ-021 After reset: state IDLE, step_valid 0, step_offset 0, step_angle 0, step_repeat 0, step_last 0, done 0, busy 0, start_ready 1.
REQ-022 reset asserted mid-run SHALL discard the run with no done pulse; first start accepted the cycle after reset deasserts.

Verification
REQ-023 Circular, count 3, step_ready held 1 -> cycles T+1..T+3: offsets 0,1,2, angles 0x20000000, 0x12E4051D, 0x09FB385B, step_last on third; done at T+4.
REQ-024 Hyperbolic, count 5 -> offsets 1,2,3,4,4,5, repeat only on second 4, angle 0x0802AC45 both times, step_last on 5.
REQ-025 Circular, count 4, step_ready low two cycles at offset 1 -> offset 1/angle 0x12E4051D held stable 3 cycles, no step skipped or duplicated.
REQ-026 Abort at offset 2 of a circular count-8 run -> step_valid 0 next cycle, no done, start_ready 1; new start accepted immediately.
REQ-027 start_count 0 -> no step_valid, done pulses one cycle after acceptance; reset mid-run -> all outputs at reset values, no done.
REQ-028 Hyperbolic count 31 -> 33 steps (repeats at 4, 13), last offset 31, angle 0x00000001.

Source files
------------

// File: rtl/angle_sequencer_if.sv
// Run-request and step-stream handshake bundle for angle_sequencer.
// The slave modport is the sequencer side; the master modport drives runs and consumes steps.
interface angle_sequencer_if #(
   parameter int p_WIDTH            = 32,
   parameter int p_ANGLE_ADDR_WIDTH = 5
);
   logic                          start_valid;
   logic                          start_ready;
   logic                          start_system;
   logic [p_ANGLE_ADDR_WIDTH-1:0] start_count;
   logic                          abort;
   logic                          step_valid;
   logic                          step_ready;
   logic [p_ANGLE_ADDR_WIDTH-1:0] step_offset;
   logic [p_WIDTH-1:0]            step_angle;
   logic                          step_repeat;
   logic                          step_last;
   logic                          done;
   logic                          busy;

   modport master (
      output start_valid, start_system, start_count, abort, step_ready,
      input  start_ready, step_valid, step_offset, step_angle, step_repeat, step_last, done, busy
   );

   modport slave (
      input  start_valid, start_system, start_count, abort, step_ready,
      output start_ready, step_valid, step_offset, step_angle, step_repeat, step_last, done, busy
   );
endinterface

// File: rtl/angle_sequencer.sv
// Issues the CORDIC iteration schedule (shift offset plus table angle) for circular or
// hyperbolic runs, one registered step per accepted handshake.
module angle_sequencer #(
   parameter int p_WIDTH            = 32,
   parameter int p_ANGLE_ADDR_WIDTH = 5
) (
   input logic              clk,
   input logic              reset,
   angle_sequencer_if.slave bus
);
   typedef enum logic {IDLE, RUN} seqState;

   // atan(2^-i) with a full turn = 2^32, truncated toward zero.
   localparam logic [31:0] circTable [32] = '{
      32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2E, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517C,
      32'h000028BE, 32'h0000145F, 32'h00000A2F, 32'h00000517,
      32'h0000028B, 32'h00000145, 32'h000000A2, 32'h00000051,
      32'h00000028, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
   };

   // atanh(2^-i) x 2^31, truncated; entry 0 is unused by the hyperbolic schedule.
   localparam logic [31:0] hypTable [32] = '{
      32'h00000000, 32'h464FA9EA, 32'h20B15DF5, 32'h1015891C,
      32'h0802AC45, 32'h04005562, 32'h02000AAB, 32'h01000155,
      32'h0080002A, 32'h00400005, 32'h00200000, 32'h00100000,
      32'h00080000, 32'h00040000, 32'h00020000, 32'h00010000,
      32'h00008000, 32'h00004000, 32'h00002000, 32'h00001000,
      32'h00000800, 32'h00000400, 32'h00000200, 32'h00000100,
      32'h00000080, 32'h00000040, 32'h00000020, 32'h00000010,
      32'h00000008, 32'h00000004, 32'h00000002, 32'h00000001
   };

   function automatic logic [p_WIDTH-1:0] tableAngle(
      input logic                          circular,
      input logic [p_ANGLE_ADDR_WIDTH-1:0] offset
   );
      logic [31:0] raw;
      raw = '0;
      if (int'(offset) < 32) raw = circular ? circTable[5'(offset)] : hypTable[5'(offset)];
      // The tables are 32-bit fractions; keep their top p_WIDTH bits.
      return p_WIDTH'({raw, 32'h0} >> (64 - p_WIDTH));
   endfunction

   // Hyperbolic convergence needs offsets 4, 13, 40, ... (k' = 3k + 1) issued twice.
   function automatic logic isRepeatOffset(input logic [p_ANGLE_ADDR_WIDTH-1:0] offset);
      longint k;
      logic   hit;
      k   = 4;
      hit = 1'b0;
      for (int i = 0; i < p_ANGLE_ADDR_WIDTH; i++) begin
         if (longint'(offset) == k) hit = 1'b1;
         k = 3 * k + 1;
      end
      return hit;
   endfunction

   function automatic logic isLastStep(
      input logic                          circular,
      input logic [p_ANGLE_ADDR_WIDTH-1:0] count,
      input logic [p_ANGLE_ADDR_WIDTH-1:0] offset,
      input logic                          repeatFlag
   );
      if (circular) return offset == count - p_ANGLE_ADDR_WIDTH'(1);
      return (offset == count) && (repeatFlag || !isRepeatOffset(offset));
   endfunction

   seqState                       state, nextState;
   logic                          circMode, circModeNext;
   logic [p_ANGLE_ADDR_WIDTH-1:0] runCount, runCountNext;
   logic                          stepValid, stepValidNext;
   logic [p_ANGLE_ADDR_WIDTH-1:0] stepOffset, stepOffsetNext;
   logic [p_WIDTH-1:0]            stepAngle, stepAngleNext;
   logic                          stepRepeat, stepRepeatNext;
   logic                          stepLast, stepLastNext;
   logic                          done, doneNext;
   logic [p_ANGLE_ADDR_WIDTH-1:0] firstOffset, advOffset;
   logic                          advRepeat;

   assign firstOffset = bus.start_system ? '0 : p_ANGLE_ADDR_WIDTH'(1);

   // The step that follows the one currently presented; never evaluated past the last step.
   always_comb begin
      advOffset = stepOffset + p_ANGLE_ADDR_WIDTH'(1);
      advRepeat = 1'b0;
      if (!circMode && !stepRepeat && isRepeatOffset(stepOffset)) begin
         advOffset = stepOffset;
         advRepeat = 1'b1;
      end
   end

   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      nextState      = state;
      circModeNext   = circMode;
      runCountNext   = runCount;
      stepValidNext  = stepValid;
      stepOffsetNext = stepOffset;
      stepAngleNext  = stepAngle;
      stepRepeatNext = stepRepeat;
      stepLastNext   = stepLast;
      doneNext       = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start_valid) begin
               if (bus.start_count == '0) begin
                  doneNext = 1'b1;
               end else begin
                  nextState      = RUN;
                  circModeNext   = bus.start_system;
                  runCountNext   = bus.start_count;
                  stepValidNext  = 1'b1;
                  stepOffsetNext = firstOffset;
                  stepAngleNext  = tableAngle(bus.start_system, firstOffset);
                  stepRepeatNext = 1'b0;
                  stepLastNext   = isLastStep(bus.start_system, bus.start_count, firstOffset, 1'b0);
               end
            end
         end
         RUN: begin
            // Abort takes priority over a step handshake in the same cycle.
            if (bus.abort) begin
               nextState     = IDLE;
               stepValidNext = 1'b0;
            end else if (bus.step_ready) begin
               if (stepLast) begin
                  nextState     = IDLE;
                  stepValidNext = 1'b0;
                  doneNext      = 1'b1;
               end else begin
                  stepOffsetNext = advOffset;
                  stepAngleNext  = tableAngle(circMode, advOffset);
                  stepRepeatNext = advRepeat;
                  stepLastNext   = isLastStep(circMode, runCount, advOffset, advRepeat);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state      <= IDLE;
         circMode   <= 1'b0;
         runCount   <= '0;
         stepValid  <= 1'b0;
         stepOffset <= '0;
         stepAngle  <= '0;
         stepRepeat <= 1'b0;
         stepLast   <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= nextState;
         circMode   <= circModeNext;
         runCount   <= runCountNext;
         stepValid  <= stepValidNext;
         stepOffset <= stepOffsetNext;
         stepAngle  <= stepAngleNext;
         stepRepeat <= stepRepeatNext;
         stepLast   <= stepLastNext;
         done       <= doneNext;
      end
   end

   assign bus.start_ready = (state == IDLE);
   assign bus.busy        = (state == RUN);
   assign bus.step_valid  = stepValid;
   assign bus.step_offset = stepOffset;
   assign bus.step_angle  = stepAngle;
   assign bus.step_repeat = stepRepeat;
   assign bus.step_last   = stepLast;
   assign bus.done        = done;
endmodule

// File: tb/tb_angle_sequencer.sv
// Directed bench for angle_sequencer: hand-computed step schedules, backpressure, abort,
// zero-length runs and reset behaviour.
module tb_angle_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   testsRun    = 0;
   int   testsFailed = 0;

   angle_sequencer_if #(.p_WIDTH(32), .p_ANGLE_ADDR_WIDTH(5)) bus ();

   angle_sequencer #(.p_WIDTH(32), .p_ANGLE_ADDR_WIDTH(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] circAngle [4] = '{32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4};
   localparam int          hypOff    [6] = '{1, 2, 3, 4, 4, 5};
   localparam logic        hypRep    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic [31:0] hypAngle  [6] = '{32'h464FA9EA, 32'h20B15DF5, 32'h1015891C,
                                             32'h0802AC45, 32'h0802AC45, 32'h04005562};
   localparam int          bpReady   [6] = '{1, 0, 0, 1, 1, 1};
   localparam int          bpOffset  [6] = '{0, 1, 1, 1, 2, 3};

   // NOTE: outputs are sampled 1 time unit after the rising edge, clear of the update.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startRun(input logic system, input logic [4:0] count);
      bus.start_valid  = 1'b1;
      bus.start_system = system;
      bus.start_count  = count;
      tick();
      bus.start_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start_valid = 1'b1; bus.start_system = 1'b1; bus.start_count = 5'd5;
      bus.abort = 1'b1; bus.step_ready = 1'b1;
      tick(); tick();
      testsRun++; if (bus.step_valid !== 1'b0) begin testsFailed++; $display("FAIL reset_step_valid: got %b expected 0", bus.step_valid); end
      testsRun++; if (bus.step_offset !== 5'd0) begin testsFailed++; $display("FAIL reset_step_offset: got %0d expected 0", bus.step_offset); end
      testsRun++; if (bus.step_angle !== 32'h0) begin testsFailed++; $display("FAIL reset_step_angle: got %h expected 0", bus.step_angle); end
      testsRun++; if (bus.step_repeat !== 1'b0) begin testsFailed++; $display("FAIL reset_step_repeat: got %b expected 0", bus.step_repeat); end
      testsRun++; if (bus.step_last !== 1'b0) begin testsFailed++; $display("FAIL reset_step_last: got %b expected 0", bus.step_last); end
      testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      testsRun++; if (bus.start_ready !== 1'b1) begin testsFailed++; $display("FAIL reset_start_ready: got %b expected 1", bus.start_ready); end
      bus.start_valid = 1'b0; bus.abort = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_circular();
      bus.step_ready = 1'b1;
      startRun(1'b1, 5'd3);
      for (int i = 0; i < 3; i++) begin
         testsRun++; if (bus.step_valid !== 1'b1) begin testsFailed++; $display("FAIL circ_valid[%0d]: got %b expected 1", i, bus.step_valid); end
         testsRun++; if (bus.step_offset !== 5'(i)) begin testsFailed++; $display("FAIL circ_offset[%0d]: got %0d expected %0d", i, bus.step_offset, i); end
         testsRun++; if (bus.step_angle !== circAngle[i]) begin testsFailed++; $display("FAIL circ_angle[%0d]: got %h expected %h", i, bus.step_angle, circAngle[i]); end
         testsRun++; if (bus.step_repeat !== 1'b0) begin testsFailed++; $display("FAIL circ_repeat[%0d]: got %b expected 0", i, bus.step_repeat); end
         testsRun++; if (bus.step_last !== (i == 2)) begin testsFailed++; $display("FAIL circ_last[%0d]: got %b expected %b", i, bus.step_last, i == 2); end
         testsRun++; if (bus.start_ready !== 1'b0 || bus.busy !== 1'b1) begin testsFailed++; $display("FAIL circ_busy[%0d]: got ready=%b busy=%b expected ready=0 busy=1", i, bus.start_ready, bus.busy); end
         // A start request in the middle of the run must be ignored.
         bus.start_valid  = (i == 1);
         bus.start_system = 1'b0;
         bus.start_count  = 5'd7;
         tick();
      end
      bus.start_valid = 1'b0;
      testsRun++; if (bus.step_valid !== 1'b0) begin testsFailed++; $display("FAIL circ_end_valid: got %b expected 0", bus.step_valid); end
      testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("FAIL circ_done: got %b expected 1", bus.done); end
      testsRun++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin testsFailed++; $display("FAIL circ_end_state: got busy=%b ready=%b expected busy=0 ready=1", bus.busy, bus.start_ready); end
      tick();
      testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("FAIL circ_done_pulse: got %b expected 0", bus.done); end
   endtask

   task automatic test_hyperbolic();
      bus.step_ready = 1'b1;
      startRun(1'b0, 5'd5);
      for (int i = 0; i < 6; i++) begin
         testsRun++; if (bus.step_valid !== 1'b1) begin testsFailed++; $display("FAIL hyp_valid[%0d]: got %b expected 1", i, bus.step_valid); end
         testsRun++; if (bus.step_offset !== 5'(hypOff[i])) begin testsFailed++; $display("FAIL hyp_offset[%0d]: got %0d expected %0d", i, bus.step_offset, hypOff[i]); end
         testsRun++; if (bus.step_repeat !== hypRep[i]) begin testsFailed++; $display("FAIL hyp_repeat[%0d]: got %b expected %b", i, bus.step_repeat, hypRep[i]); end
         testsRun++; if (bus.step_angle !== hypAngle[i]) begin testsFailed++; $display("FAIL hyp_angle[%0d]: got %h expected %h", i, bus.step_angle, hypAngle[i]); end
         testsRun++; if (bus.step_last !== (i == 5)) begin testsFailed++; $display("FAIL hyp_last[%0d]: got %b expected %b", i, bus.step_last, i == 5); end
         tick();
      end
      testsRun++; if (bus.done !== 1'b1 || bus.step_valid !== 1'b0) begin testsFailed++; $display("FAIL hyp_done: got done=%b valid=%b expected done=1 valid=0", bus.done, bus.step_valid); end
   endtask

   task automatic test_back_to_back();
      // Start again in the very cycle the previous run reports done.
      startRun(1'b1, 5'd1);
      testsRun++; if (bus.step_valid !== 1'b1 || bus.step_offset !== 5'd0) begin testsFailed++; $display("FAIL b2b_first: got valid=%b offset=%0d expected valid=1 offset=0", bus.step_valid, bus.step_offset); end
      testsRun++; if (bus.step_angle !== 32'h20000000) begin testsFailed++; $display("FAIL b2b_angle: got %h expected 20000000", bus.step_angle); end
      testsRun++; if (bus.step_last !== 1'b1) begin testsFailed++; $display("FAIL b2b_last: got %b expected 1", bus.step_last); end
      tick();
      testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("FAIL b2b_done: got %b expected 1", bus.done); end
      tick();
   endtask

   task automatic test_backpressure();
      bus.step_ready = 1'b1;
      startRun(1'b1, 5'd4);
      for (int i = 0; i < 6; i++) begin
         testsRun++; if (bus.step_valid !== 1'b1) begin testsFailed++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.step_valid); end
         testsRun++; if (bus.step_offset !== 5'(bpOffset[i])) begin testsFailed++; $display("FAIL bp_offset[%0d]: got %0d expected %0d", i, bus.step_offset, bpOffset[i]); end
         testsRun++; if (bus.step_angle !== circAngle[bpOffset[i]]) begin testsFailed++; $display("FAIL bp_angle[%0d]: got %h expected %h", i, bus.step_angle, circAngle[bpOffset[i]]); end
         testsRun++; if (bus.step_last !== (bpOffset[i] == 3)) begin testsFailed++; $display("FAIL bp_last[%0d]: got %b expected %b", i, bus.step_last, bpOffset[i] == 3); end
         bus.step_ready = (bpReady[i] != 0);
         tick();
      end
      bus.step_ready = 1'b1;
      testsRun++; if (bus.done !== 1'b1 || bus.step_valid !== 1'b0) begin testsFailed++; $display("FAIL bp_done: got done=%b valid=%b expected done=1 valid=0", bus.done, bus.step_valid); end
      tick();
   endtask

   task automatic test_abort();
      bus.step_ready = 1'b1;
      startRun(1'b1, 5'd8);
      tick(); tick();
      testsRun++; if (bus.step_offset !== 5'd2) begin testsFailed++; $display("FAIL abort_pre_offset: got %0d expected 2", bus.step_offset); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      testsRun++; if (bus.step_valid !== 1'b0) begin testsFailed++; $display("FAIL abort_valid: got %b expected 0", bus.step_valid); end
      testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("FAIL abort_done: got %b expected 0", bus.done); end
      testsRun++; if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin testsFailed++; $display("FAIL abort_state: got ready=%b busy=%b expected ready=1 busy=0", bus.start_ready, bus.busy); end
      tick();
      testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("FAIL abort_late_done: got %b expected 0", bus.done); end
      // Abort held while idle must not block a new start.
      bus.abort = 1'b1;
      startRun(1'b1, 5'd2);
      bus.abort = 1'b0;
      testsRun++; if (bus.step_valid !== 1'b1 || bus.step_offset !== 5'd0) begin testsFailed++; $display("FAIL abort_restart: got valid=%b offset=%0d expected valid=1 offset=0", bus.step_valid, bus.step_offset); end
      tick();
      testsRun++; if (bus.step_offset !== 5'd1 || bus.step_last !== 1'b1) begin testsFailed++; $display("FAIL abort_restart_last: got offset=%0d last=%b expected offset=1 last=1", bus.step_offset, bus.step_last); end
      tick();
      testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("FAIL abort_restart_done: got %b expected 1", bus.done); end
      tick();
   endtask

   task automatic test_zero_count();
      startRun(1'b0, 5'd0);
      testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("FAIL zero_done: got %b expected 1", bus.done); end
      testsRun++; if (bus.step_valid !== 1'b0) begin testsFailed++; $display("FAIL zero_valid: got %b expected 0", bus.step_valid); end
      testsRun++; if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin testsFailed++; $display("FAIL zero_state: got ready=%b busy=%b expected ready=1 busy=0", bus.start_ready, bus.busy); end
      tick();
      testsRun++; if (bus.done !== 1'b0 || bus.step_valid !== 1'b0) begin testsFailed++; $display("FAIL zero_after: got done=%b valid=%b expected done=0 valid=0", bus.done, bus.step_valid); end
   endtask

   task automatic test_reset_mid_run();
      bus.step_ready = 1'b1;
      startRun(1'b0, 5'd10);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      testsRun++; if (bus.step_valid !== 1'b0 || bus.step_offset !== 5'd0) begin testsFailed++; $display("FAIL midreset_step: got valid=%b offset=%0d expected valid=0 offset=0", bus.step_valid, bus.step_offset); end
      testsRun++; if (bus.step_angle !== 32'h0 || bus.step_repeat !== 1'b0 || bus.step_last !== 1'b0) begin testsFailed++; $display("FAIL midreset_fields: got angle=%h repeat=%b last=%b expected 0/0/0", bus.step_angle, bus.step_repeat, bus.step_last); end
      testsRun++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin testsFailed++; $display("FAIL midreset_ctrl: got done=%b busy=%b ready=%b expected 0/0/1", bus.done, bus.busy, bus.start_ready); end
      startRun(1'b1, 5'd1);
      testsRun++; if (bus.step_valid !== 1'b1 || bus.step_last !== 1'b1) begin testsFailed++; $display("FAIL midreset_restart: got valid=%b last=%b expected 1/1", bus.step_valid, bus.step_last); end
      tick();
      testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("FAIL midreset_done: got %b expected 1", bus.done); end
      tick();
   endtask

   task automatic test_long_hyperbolic();
      int   expOff [$];
      logic expRep [$];
      int   idx;
      for (int off = 1; off <= 31; off++) begin
         expOff.push_back(off); expRep.push_back(1'b0);
         if (off == 4 || off == 13) begin expOff.push_back(off); expRep.push_back(1'b1); end
      end
      bus.step_ready = 1'b1;
      startRun(1'b0, 5'd31);
      idx = 0;
      for (int cyc = 0; cyc < 100 && bus.step_valid === 1'b1; cyc++) begin
         if (idx < expOff.size()) begin
            testsRun++; if (bus.step_offset !== 5'(expOff[idx]) || bus.step_repeat !== expRep[idx]) begin testsFailed++; $display("FAIL long_step[%0d]: got offset=%0d repeat=%b expected offset=%0d repeat=%b", idx, bus.step_offset, bus.step_repeat, expOff[idx], expRep[idx]); end
            testsRun++; if (bus.step_last !== (idx == expOff.size() - 1)) begin testsFailed++; $display("FAIL long_last[%0d]: got %b expected %b", idx, bus.step_last, idx == expOff.size() - 1); end
            if (expOff[idx] == 13 && expRep[idx]) begin
               testsRun++; if (bus.step_angle !== 32'h00040000) begin testsFailed++; $display("FAIL long_angle13: got %h expected 00040000", bus.step_angle); end
            end
            if (idx == expOff.size() - 1) begin
               testsRun++; if (bus.step_angle !== 32'h00000001) begin testsFailed++; $display("FAIL long_angle31: got %h expected 00000001", bus.step_angle); end
            end
         end
         idx++;
         tick();
      end
      testsRun++; if (idx != 33) begin testsFailed++; $display("FAIL long_step_count: got %0d expected 33", idx); end
      testsRun++; if (bus.done !== 1'b1) begin testsFailed++; $display("FAIL long_done: got %b expected 1", bus.done); end
      tick();
   endtask

   initial begin
      reset            = 1'b1;
      bus.start_valid  = 1'b0;
      bus.start_system = 1'b0;
      bus.start_count  = '0;
      bus.abort        = 1'b0;
      bus.step_ready   = 1'b0;
      test_reset();
      test_circular();
      test_hyperbolic();
      test_back_to_back();
      test_backpressure();
      test_abort();
      test_zero_count();
      test_reset_mid_run();
      test_long_hyperbolic();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
